reg_file_sb: RTL and testbench

Parametrised integer register file with an integrated write scoreboard for the pipelined core. It has NRD combinational read ports with write-first bypass and one synchronous write port. It also tracks which registers have an issued but not yet written-back producer, so decode can stall on RAW/WAW hazards. It sits between decode (reads, issue reservation) and writeback (writes, busy release). All state has a true asynchronous reset, so initial stack and global pointers are restored on every reset, not only at configuration.

---
 rtl/reg_file_sb_pkg.sv | 12 +
 rtl/reg_file_sb_if.sv | 32 +++
 rtl/reg_file_sb_scoreboard.sv | 57 +++++
 rtl/reg_file_sb.sv | 75 +++++++
 tb/tb_reg_file_sb.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the integer register file and its write scoreboard.
// Reset values of the stack and global pointers live here so every user agrees.
package reg_file_pkg;

  localparam int          XLEN     = 32;
  localparam int          REG_ZERO = 0;
  localparam int          REG_SP   = 2;
  localparam int          REG_GP   = 3;
  localparam logic [31:0] SP_INIT  = 32'h0000_2ffc;
  localparam logic [31:0] GP_INIT  = 32'h0000_1800;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bundle for reg_file_sb: read ports, write port, issue reservation.
// All slave outputs are combinational; iss_ready is the only backpressure signal.
interface reg_file_sb_if #(
  parameter int XLEN = reg_file_pkg::XLEN,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output ra, we, wa, wd, iss_valid, iss_rd, flush,
    input  rd, rd_busy, iss_ready, busy_cnt
  );

  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_rd, flush,
    output rd, rd_busy, iss_ready, busy_cnt
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on accepted issue, cleared on writeback or flush.
// Zero-latency status outputs; iss_ready deasserts on a WAW against a live reservation.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);
  import reg_file_pkg::*;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Release before set, so a same-cycle writeback and re-reservation leaves the bit busy.
  always_comb begin
    busy_nxt = busy;
    if (we) begin
      busy_nxt[wa] = 1'b0;
    end
    if (flush) begin
      busy_nxt = '0;
    end else if (iss_valid && iss_ready && iss_rd != AW'(REG_ZERO)) begin
      busy_nxt[iss_rd] = 1'b1;
    end
  end

  always_comb begin
    iss_ready = (iss_rd == AW'(REG_ZERO)) || !busy[iss_rd] || (we && wa == iss_rd);
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = busy[ra[i*AW +: AW]] && !(we && wa == ra[i*AW +: AW]);
    end
    busy_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt = busy_cnt + (AW+1)'(busy[i]);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-first bypassed reads, one write port and a RAW/WAW scoreboard.
// Reads/status are 0-latency; REG_FILE_SB_DBG_EN adds an unbypassed debug read port.
module reg_file_sb #(
  parameter int              XLEN    = reg_file_pkg::XLEN,
  parameter int              NREG    = 32,
  parameter int              NRD     = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(reg_file_pkg::SP_INIT),
  parameter logic [XLEN-1:0] GP_INIT = XLEN'(reg_file_pkg::GP_INIT)
) (
  input  logic               clk,
  input  logic               rstn,
  reg_file_sb_if.slave       bus
`ifdef REG_FILE_SB_DBG_EN
  ,
  input  logic [$clog2(NREG)-1:0] dbg_ra,
  output logic [XLEN-1:0]         dbg_rd
`endif
);
  import reg_file_pkg::*;

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] rf [NREG];

  // Pointer registers are restored on every reset, not only at power-up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        if (i == REG_SP) begin
          rf[i] <= SP_INIT;
        end else if (i == REG_GP) begin
          rf[i] <= GP_INIT;
        end else begin
          rf[i] <= '0;
        end
      end
    end else if (bus.we && bus.wa != AW'(REG_ZERO)) begin
      rf[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    bus.rd = '0;
    for (int i = 0; i < NRD; i++) begin
      if (bus.we && bus.wa == bus.ra[i*AW +: AW] && bus.ra[i*AW +: AW] != AW'(REG_ZERO)) begin
        bus.rd[i*XLEN +: XLEN] = bus.wd;
      end else begin
        bus.rd[i*XLEN +: XLEN] = rf[bus.ra[i*AW +: AW]];
      end
    end
  end

`ifdef REG_FILE_SB_DBG_EN
  assign dbg_rd = rf[dbg_ra];
`endif

  reg_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .ra        (bus.ra),
    .rd_busy   (bus.rd_busy),
    .we        (bus.we),
    .wa        (bus.wa),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .iss_ready (bus.iss_ready),
    .flush     (bus.flush),
    .busy_cnt  (bus.busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a cycle-by-cycle vector table plus an async-reset sequence.
module tb_reg_file_sb;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  reg_file_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

`ifdef REG_FILE_SB_DBG_EN
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;
`endif

  reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus)
`ifdef REG_FILE_SB_DBG_EN
    ,
    .dbg_ra (dbg_ra),
    .dbg_rd (dbg_rd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_rdy;
    logic [5:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic iv, input logic [4:0] ird, input logic fl,
                              input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                              input logic [1:0] e_busy, input logic e_rdy, input logic [5:0] e_cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1;
    v.iv = iv; v.ird = ird; v.fl = fl;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.we        = v.we;
    bus.wa        = v.wa;
    bus.wd        = v.wd;
    bus.ra        = {v.ra1, v.ra0};
    bus.iss_valid = v.iv;
    bus.iss_rd    = v.ird;
    bus.flush     = v.fl;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.ra = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.flush = 1'b0;
`ifdef REG_FILE_SB_DBG_EN
    dbg_ra = 5'd2;
`endif

    //                we  wa     wd             ra0    ra1    iv  ird    fl   rd0            rd1            busy   rdy  cnt
    vecs[0]  = mk(1'b0, 5'd0,  32'h0,         5'd2,  5'd3,  1'b0, 5'd0,  1'b0, 32'h2ffc,     32'h1800,     2'b00, 1'b1, 6'd0);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b1, 6'd0);
    vecs[2]  = mk(1'b1, 5'd5,  32'hdeadbeef,  5'd5,  5'd2,  1'b0, 5'd0,  1'b0, 32'hdeadbeef, 32'h2ffc,     2'b00, 1'b1, 6'd0);
    vecs[3]  = mk(1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  1'b0, 5'd0,  1'b0, 32'hdeadbeef, 32'hdeadbeef, 2'b00, 1'b1, 6'd0);
    vecs[4]  = mk(1'b1, 5'd0,  32'h1234,      5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 32'h0,        32'h0,        2'b00, 1'b1, 6'd0);
    vecs[5]  = mk(1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  1'b1, 5'd7,  1'b0, 32'h0,        32'hdeadbeef, 2'b00, 1'b1, 6'd0);
    vecs[6]  = mk(1'b0, 5'd0,  32'h0,         5'd0,  5'd7,  1'b1, 5'd7,  1'b0, 32'h0,        32'h0,        2'b10, 1'b0, 6'd1);
    vecs[7]  = mk(1'b1, 5'd7,  32'h77,        5'd7,  5'd7,  1'b0, 5'd7,  1'b0, 32'h77,       32'h77,       2'b00, 1'b1, 6'd1);
    vecs[8]  = mk(1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  1'b0, 5'd7,  1'b0, 32'h77,       32'h77,       2'b00, 1'b1, 6'd0);
    vecs[9]  = mk(1'b0, 5'd0,  32'h0,         5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 32'h0,        32'h0,        2'b00, 1'b1, 6'd0);
    vecs[10] = mk(1'b1, 5'd9,  32'h99,        5'd9,  5'd9,  1'b1, 5'd9,  1'b0, 32'h99,       32'h99,       2'b00, 1'b1, 6'd1);
    vecs[11] = mk(1'b0, 5'd0,  32'h0,         5'd9,  5'd9,  1'b0, 5'd9,  1'b0, 32'h99,       32'h99,       2'b11, 1'b0, 6'd1);
    vecs[12] = mk(1'b1, 5'd9,  32'h9a,        5'd9,  5'd4,  1'b1, 5'd4,  1'b0, 32'h9a,       32'h0,        2'b00, 1'b1, 6'd1);
    vecs[13] = mk(1'b0, 5'd0,  32'h0,         5'd4,  5'd6,  1'b1, 5'd6,  1'b0, 32'h0,        32'h0,        2'b01, 1'b1, 6'd1);
    vecs[14] = mk(1'b0, 5'd0,  32'h0,         5'd6,  5'd8,  1'b1, 5'd8,  1'b0, 32'h0,        32'h0,        2'b01, 1'b1, 6'd2);
    vecs[15] = mk(1'b1, 5'd11, 32'hbb,        5'd8,  5'd11, 1'b1, 5'd10, 1'b1, 32'h0,        32'hbb,       2'b01, 1'b1, 6'd3);
    vecs[16] = mk(1'b0, 5'd0,  32'h0,         5'd10, 5'd11, 1'b0, 5'd10, 1'b0, 32'h0,        32'hbb,       2'b00, 1'b1, 6'd0);
    vecs[17] = mk(1'b0, 5'd0,  32'h0,         5'd8,  5'd4,  1'b0, 5'd4,  1'b0, 32'h0,        32'h0,        2'b00, 1'b1, 6'd0);

    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("rd0",       i, bus.rd[31:0],            vecs[i].e_rd0);
      chk("rd1",       i, bus.rd[63:32],           vecs[i].e_rd1);
      chk("rd_busy",   i, 32'(bus.rd_busy),        32'(vecs[i].e_busy));
      chk("iss_ready", i, 32'(bus.iss_ready),      32'(vecs[i].e_rdy));
      chk("busy_cnt",  i, 32'(bus.busy_cnt),       32'(vecs[i].e_cnt));
    end

`ifdef REG_FILE_SB_DBG_EN
    // Debug port ignores the bypass: an in-flight write to 2 must not show.
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd2; bus.wd = 32'h5555; bus.iss_valid = 1'b0; bus.flush = 1'b0;
    dbg_ra = 5'd2;
    #1;
    chk("dbg_nobypass", 100, dbg_rd, 32'h2ffc);
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    chk("dbg_after_wr", 101, dbg_rd, 32'h5555);
`endif

    // Write reg 2 and reserve 12, then pull reset mid-cycle during another write.
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd2; bus.wd = 32'h1111;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd12; bus.flush = 1'b0;
    bus.ra = {5'd12, 5'd2};
    @(posedge clk);
    #1;
    chk("pre_rst_rf2",  200, bus.rd[31:0],        32'h1111);
    chk("pre_rst_cnt",  201, 32'(bus.busy_cnt),   32'd1);
    #1;
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h55; bus.iss_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_rf2",      202, bus.rd[31:0],        32'h2ffc);
    chk("rst_rf12",     203, bus.rd[63:32],       32'h0);
    chk("rst_rd_busy",  204, 32'(bus.rd_busy),    32'd0);
    chk("rst_cnt",      205, 32'(bus.busy_cnt),   32'd0);
    chk("rst_ready",    206, 32'(bus.iss_ready),  32'd1);
    @(negedge clk);
    bus.we = 1'b0;
    rstn = 1'b1;
    bus.ra = {5'd3, 5'd5};
    #1;
    chk("rst_rf5",      207, bus.rd[31:0],        32'h0);
    chk("rst_rf3",      208, bus.rd[63:32],       32'h1800);
    chk("rst_cnt2",     209, 32'(bus.busy_cnt),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
